// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction RAM controller.
// The controller's state enum, default NOP word and sticky error bit positions.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        HANDOFF = 2'd1,
        RUN     = 2'd2
    } imem_state_t;

    localparam logic [31:0] NOP_INSN_DEFAULT = 32'hE1A00000;

    localparam int ERR_OVF   = 0;
    localparam int ERR_FETCH = 1;

endpackage

// File: rtl/imem_ctrl.sv
// Instruction RAM owner arbitration: boot loader writes first, then fetch reads.
// Build option IMEM_CTRL_PRELOAD_EN starts in RUN for file-preloaded RAM simulation.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int          AW       = 8,
    parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   f_addr,
    output logic [31:0]   f_rdata,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          reload,
    output logic [AW-1:0] m_addr,
    output logic          m_we,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    output logic          cpu_hold,
    output logic [AW:0]   ld_count,
    output logic [1:0]    err
);

`ifdef IMEM_CTRL_PRELOAD_EN
    localparam imem_state_t RESET_STATE = RUN;
`else
    localparam imem_state_t RESET_STATE = LOAD;
`endif

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    imem_state_t   state;
    imem_state_t   state_next;
    logic [AW-1:0] wptr;
    logic          accept;
    logic          at_end;
    logic          fetch_bad;

    assign accept    = (state == LOAD) && ld_valid;
    assign at_end    = (wptr == LAST_ADDR);
    assign fetch_bad = (f_addr[1:0] != 2'b00) || (f_addr[31:AW+2] != '0);

    // The top RAM word always ends a load, so the write pointer never wraps.
    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        cpu_hold   = 1'b1;
        m_addr     = wptr;
        m_we       = 1'b0;
        m_wdata    = ld_data;
        f_rdata    = NOP_INSN;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                m_we     = ld_valid;
                if (ld_valid && (ld_last || at_end)) begin
                    state_next = HANDOFF;
                end
            end
            HANDOFF: begin
                state_next = RUN;
            end
            RUN: begin
                cpu_hold = 1'b0;
                m_addr   = f_addr[AW+1:2];
                f_rdata  = fetch_bad ? NOP_INSN : m_rdata;
                if (reload) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    // Error flags are sticky until reset; a reload keeps them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RESET_STATE;
            wptr     <= '0;
            ld_count <= '0;
            err      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                ld_count <= ld_count + (AW+1)'(1);
                if (!at_end) begin
                    wptr <= wptr + AW'(1);
                end else if (!ld_last) begin
                    err[ERR_OVF] <= 1'b1;
                end
            end
            if (state == RUN) begin
                if (fetch_bad) begin
                    err[ERR_FETCH] <= 1'b1;
                end
                if (reload) begin
                    wptr     <= '0;
                    ld_count <= '0;
                end
            end
        end
    end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Controller for the pipeline's single-port instruction RAM. It sequences the RAM between two owners: a program loader that streams instruction words in after reset, and the fetch stage that reads from it afterwards. While loading, it holds the pipeline via `cpu_hold`. Once the last word is written, it hands the RAM to fetch. It sits between the fetch stage, the boot-loader stream and a writable instruction RAM.

## Interface
Parameters:
- `AW`, 8: word-address width; RAM depth is 2**AW words (256).
- `NOP_INSN`, 32'hE1A00000: word returned to fetch when the RAM is not readable (MOV r0,r0).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `f_addr` in 32: fetch byte address (PC).
- `f_rdata` out 32: instruction to the fetch stage.
- `ld_valid` in 1: loader word valid.
- `ld_data` in 32: loader instruction word.
- `ld_last` in 1: marks the final word of a load.
- `ld_ready` out 1: controller accepts a loader word.
- `reload` in 1: single-cycle request to re-enter load mode.
- `m_addr` out AW: RAM word address.
- `m_we` out 1: RAM write enable.
- `m_wdata` out 32: RAM write data.
- `m_rdata` in 32: RAM combinational read data.
- `cpu_hold` out 1: keeps the pipeline in reset/stall.
- `ld_count` out AW+1: number of words written in the current or last load.
- `err` out 2: sticky error flags; [0] loader overflow, [1] fetch misaligned or out of range.

## Operation
- FSM states are LOAD, HANDOFF and RUN. The reset state is LOAD (see Configuration).
- LOAD state:
  - `ld_ready`=1, `cpu_hold`=1, `m_addr`=wptr, `m_we`=`ld_valid`, `m_wdata`=`ld_data`, `f_rdata`=`NOP_INSN`.
  - Each accepted word (`ld_valid`&`ld_ready`) writes RAM[wptr], then increments wptr and `ld_count`.
- End of load:
  - An accepted word with `ld_last`=1 moves the FSM to HANDOFF.
  - An accepted word at wptr = 2**AW-1 without `ld_last` is written, sets `err`[0], and is treated as last. wptr does not wrap.
- HANDOFF state: one cycle. `ld_ready`=0, `m_we`=0, `cpu_hold`=1. Next state is RUN.
- RUN state:
  - `cpu_hold`=0, `ld_ready`=0, `m_we`=0, `m_addr`=`f_addr`[AW+1:2], `f_rdata`=`m_rdata`.
  - If `f_addr`[1:0]≠0 or `f_addr`[31:AW+2]≠0, `f_rdata`=`NOP_INSN` and `err`[1] is set.
- Reload:
  - `reload`=1 in RUN moves the FSM to LOAD and clears wptr and `ld_count` on the next edge. `err` is kept.
  - `reload` is ignored in LOAD and HANDOFF.
- `err` bits are cleared only by `reset`.
- `ld_valid` with `ld_ready`=0 is not consumed. The loader must hold its word until it is accepted.

## Timing
- Reset values: state=LOAD, wptr=0, `ld_count`=0, `err`=0, `cpu_hold`=1, `ld_ready`=1, `m_we`=0, `f_rdata`=`NOP_INSN`.
- Writes take effect at the rising edge of the accepting cycle. Throughput is one word per cycle.
- Fetch read is combinational, 0 cycles from `f_addr` to `f_rdata` in RUN.
- `cpu_hold` falls one cycle after the last word is accepted, i.e. the HANDOFF cycle precedes the first fetch.
- `cpu_hold` rises on the edge after `reload` is sampled in RUN.
- Reset asserted mid-load returns all state to reset values immediately. RAM contents are untouched.
- If `reload` and `ld_valid` are both high in RUN, `reload` wins and the word is not written. It is accepted in LOAD on a later cycle.

## Configuration
- Macro `IMEM_CTRL_PRELOAD_EN`.
- Defined: the reset state is RUN. `cpu_hold`=0 and `ld_ready`=0 at reset, for simulation with a file-preloaded RAM. `reload` still enters LOAD.
- Undefined: the reset state is LOAD as specified above.

## Structure
- Package `imem_ctrl_pkg` holds:
  - the state enum `imem_state_t` (LOAD, HANDOFF, RUN);
  - the `NOP_INSN` default constant;
  - the error bit index constants `ERR_OVF`=0 and `ERR_FETCH`=1.
- No sub-module. The RAM is external: a writable instruction RAM with a combinational read port, instantiated alongside.

## Test plan
- Reset, then stream 4 words (A0..A3, `ld_last` on A3):
  - RAM[0..3]=A0..A3 and `ld_count`=4.
  - `cpu_hold` drops 1 cycle after A3 is accepted.
  - `f_addr`=8 then returns A2.
- Loader gaps: `ld_valid` toggled 1,0,1 → only 2 writes, to addresses 0 and 1, with `ld_count`=2.
- Overflow with AW=2: 5 words without `ld_last`:
  - words 0..3 are written, `err`[0]=1, and the FSM enters RUN after word 3;
  - word 4 is not accepted (`ld_ready`=0).
- RUN fetch errors:
  - `f_addr`=32'h6 → `f_rdata`=32'hE1A00000, `err`[1]=1;
  - `f_addr`=32'h400 with AW=8 → NOP, and `err`[1] stays 1.
- `reload` in RUN, then load 2 words B0,B1:
  - `cpu_hold`=1 the next cycle and `ld_count` resets to 0 then reaches 2;
  - RAM[0..1]=B0,B1, and RAM[2] keeps the old A2.
- Reset asserted mid-load after 2 words: wptr=0, `ld_count`=0, `cpu_hold`=1, and the next word writes address 0.
